data_memory_ctrl: RTL and testbench
===================================

Name: data_memory_ctrl

Overview:
- Parametrised successor to the single-cycle data memory in the MEM stage. Byte-addressed and little-endian.
- Supports byte, halfword and word loads/stores with sign or zero extension, per-lane byte writes, alignment and bounds checking.
- Has a configurable wait-state latency behind a req/busy/ack handshake. This lets the pipeline model slower memories and exercise stall logic.

Parameters:
- DWIDTH, 32, data word width; only 32 is supported; any other value is an elaboration error.
- AWIDTH_MEM, 32, byte address width.
- DEPTH, 256, number of DWIDTH-bit words in the array.
- WAIT_CYCLES, 1, extra wait states between accept and access; range 0..15.

Ports:
- m_clk  input  1  clock.
- m_rst  input  1  reset, asynchronous, active-low.
- m_i_req  input  1  request strobe; sampled only while not busy.
- m_i_we  input  1  1 = store, 0 = load.
- m_i_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
- m_i_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- m_i_addr  input  AWIDTH_MEM  byte address (ALU result).
- m_i_store_data  input  DWIDTH  store data, right-justified.
- m_o_busy  output  1  transaction in flight; the pipeline must stall.
- m_o_ack  output  1  one-cycle completion pulse.
- m_o_load_data  output  DWIDTH  extended load result; valid when m_o_ack=1.
- m_o_err  output  1  valid with m_o_ack: misaligned, out-of-bounds, or reserved size.

Behaviour:
- Reset (asynchronous, m_rst=0):
  - Whole array cleared to 0; FSM goes to IDLE; wait counter cleared.
  - m_o_busy=0, m_o_ack=0, m_o_load_data=0, m_o_err=0.
  - Any in-flight transaction is dropped: no write and no ack.
- FSM states: IDLE, WAIT.
- IDLE:
  - If m_i_req=1 at a rising edge, latch we/size/unsigned/addr/store_data, load cnt<=WAIT_CYCLES, go to WAIT.
  - m_o_busy is combinational: (state==WAIT).
- WAIT:
  - If cnt!=0, decrement cnt.
  - If cnt==0, perform the access on this edge, pulse m_o_ack=1 for the next cycle, and return to IDLE.
- Latency: for a request accepted at edge N, m_o_ack is high in the cycle after edge N+1+WAIT_CYCLES. With WAIT_CYCLES=0, ack follows the accept cycle directly.
- Back-to-back: a new request may be accepted in the same cycle that m_o_ack is high (state is IDLE). m_i_req while busy is ignored, not queued.
- Addressing: word index = addr[AWIDTH_MEM-1:2]; lane = addr[1:0]; byte lane k = bits [8k+7:8k].
- Error conditions (any one sets m_o_err):
  - size=01 with addr[0]=1.
  - size=10 with addr[1:0]!=0.
  - size=11.
  - word index >= DEPTH.
- On error:
  - No array write.
  - m_o_load_data=0 and m_o_err=1 with the ack.
  - Handshake timing is unchanged.
- Stores (no error):
  - Byte: only lane addr[1:0] gets store_data[7:0].
  - Half: lanes addr[1]*2 and +1 get store_data[15:0].
  - Word: all lanes written.
  - Other lanes are untouched.
- Loads (no error):
  - Selected byte/half is right-justified.
  - Extension is per m_i_unsigned: sign-extend replicates bit 7 / bit 15; word loads ignore m_i_unsigned.
  - m_o_load_data holds its value after ack until the next completing load or error. A completing store leaves it unchanged.
- m_o_err holds its value until the next ack.
- Reads and writes go through the same registered access. The access reads the array value present before that edge; no same-edge forwarding is needed because only one transaction is in flight.

Test Plan:
- Reset clears state: write words 0..3, assert m_rst=0 for 1 cycle, then LW addr 0x0/0xC -> load_data=0x00000000, err=0, busy=0 immediately after reset.
- Latency: WAIT_CYCLES=1. SW 0xDEADBEEF @0x10, then LW @0x10 -> busy high 2 cycles per transaction, ack 2 cycles after accept, load_data=0xDEADBEEF. Repeat with WAIT_CYCLES=0 and 3 -> ack delay 1 and 4 cycles.
- Byte lanes and extension: SW 0 @0x20, SB 0x80 @0x23 -> LW @0x20 = 0x80000000. LB @0x23 = 0xFFFFFF80; LBU @0x23 = 0x00000080. SH 0x8001 @0x22 then LH @0x22 = 0xFFFF8001, LHU = 0x00008001.
- Errors:
  - SH @0x21 -> ack with err=1; following LW @0x20 unchanged.
  - LW @0x22 -> err=1, load_data=0.
  - size=11 -> err=1.
  - LW @ (DEPTH*4) -> err=1.
- Handshake: hold m_i_req=1 continuously with changing addresses -> one accept per non-busy cycle; requests during busy are ignored. Back-to-back accept in the ack cycle gives ack spacing of 2+WAIT_CYCLES.
- Reset mid-op: SW 0x12345678 @0x30 with WAIT_CYCLES=3, assert m_rst during WAIT -> no ack, busy=0; after reset LW @0x30 = 0x00000000.

Source files
------------

// File: rtl/data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_ctrl
// Brief    : Byte-addressed little-endian data memory with req/busy/ack
//            handshake, configurable wait states, and lane/extension logic.
// Revision : 1.0
// ============================================================================
module data_memory_ctrl #(
    parameter int DWIDTH      = 32,
    parameter int AWIDTH_MEM  = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  m_clk,
    input  logic                  m_rst,
    input  logic                  m_i_req,
    input  logic                  m_i_we,
    input  logic [1:0]            m_i_size,
    input  logic                  m_i_unsigned,
    input  logic [AWIDTH_MEM-1:0] m_i_addr,
    input  logic [DWIDTH-1:0]     m_i_store_data,
    output logic                  m_o_busy,
    output logic                  m_o_ack,
    output logic [DWIDTH-1:0]     m_o_load_data,
    output logic                  m_o_err
);

    localparam int               c_IDX_W     = AWIDTH_MEM - 2;
    localparam int               c_MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_IDX_W:0] c_DEPTH_IDX = (c_IDX_W + 1)'(DEPTH);
    localparam logic [3:0]       c_WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [1:0]       c_SIZE_B    = 2'b00;
    localparam logic [1:0]       c_SIZE_H    = 2'b01;
    localparam logic [1:0]       c_SIZE_W    = 2'b10;
    localparam logic [0:0]       c_ST_IDLE   = 1'b0;
    localparam logic [0:0]       c_ST_WAIT   = 1'b1;

    generate
        if (DWIDTH != 32) begin : g_bad_dwidth
            $error("data_memory_ctrl: DWIDTH must be 32");
        end
        if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
            $error("data_memory_ctrl: WAIT_CYCLES must be in 0..15");
        end
    endgenerate

    logic [0:0]            r_state;
    logic [0:0]            w_state_next;
    logic [3:0]            r_cnt;
    logic                  r_we;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic [AWIDTH_MEM-1:0] r_addr;
    logic [DWIDTH-1:0]     r_wdata;
    logic [DWIDTH-1:0]     r_mem [DEPTH];
    logic                  r_ack;
    logic                  r_err;
    logic [DWIDTH-1:0]     r_load_data;

    logic                  w_accept;
    logic                  w_access;
    logic [c_IDX_W-1:0]    w_idx;
    logic [c_MEM_AW-1:0]   w_mem_idx;
    logic [1:0]            w_lane;
    logic                  w_oob;
    logic                  w_misalign;
    logic                  w_err;
    logic [3:0]            w_be;
    logic [DWIDTH-1:0]     w_wlanes;
    logic [DWIDTH-1:0]     w_rdata;
    logic [7:0]            w_rbyte;
    logic [15:0]           w_rhalf;
    logic [DWIDTH-1:0]     w_ext;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge m_clk or negedge m_rst) begin
        if (!m_rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (m_i_req)      w_state_next = c_ST_WAIT;
            c_ST_WAIT: if (r_cnt == 4'd0) w_state_next = c_ST_IDLE;
            default:                     w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        m_o_busy = (r_state == c_ST_WAIT);
        w_accept = (r_state == c_ST_IDLE) && m_i_req;
        w_access = (r_state == c_ST_WAIT) && (r_cnt == 4'd0);
    end

    // ------------------------------------------------- request latch / count
    always_ff @(posedge m_clk or negedge m_rst) begin
        if (!m_rst) begin
            r_cnt      <= 4'd0;
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else if (w_accept) begin
            r_cnt      <= c_WAIT_INIT;
            r_we       <= m_i_we;
            r_size     <= m_i_size;
            r_unsigned <= m_i_unsigned;
            r_addr     <= m_i_addr;
            r_wdata    <= m_i_store_data;
        end else if (m_o_busy && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // ------------------------------------------------ address decode / check
    assign w_idx      = r_addr[AWIDTH_MEM-1:2];
    assign w_mem_idx  = w_idx[c_MEM_AW-1:0];
    assign w_lane     = r_addr[1:0];
    assign w_oob      = ({1'b0, w_idx} >= c_DEPTH_IDX);
    assign w_misalign = ((r_size == c_SIZE_H) && r_addr[0])
                     || ((r_size == c_SIZE_W) && (r_addr[1:0] != 2'b00))
                     || (r_size == 2'b11);
    assign w_err      = w_oob || w_misalign;

    // Store data is replicated across lanes so the enable mask alone picks them.
    always_comb begin
        w_be     = 4'b0000;
        w_wlanes = r_wdata;
        case (r_size)
            c_SIZE_B: begin
                w_be     = 4'b0001 << w_lane;
                w_wlanes = {4{r_wdata[7:0]}};
            end
            c_SIZE_H: begin
                w_be     = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{r_wdata[15:0]}};
            end
            c_SIZE_W: w_be = 4'b1111;
            default:  w_be = 4'b0000;
        endcase
    end

    assign w_rdata = r_mem[w_mem_idx];
    assign w_rbyte = w_rdata[{w_lane, 3'b000} +: 8];
    assign w_rhalf = r_addr[1] ? w_rdata[31:16] : w_rdata[15:0];

    always_comb begin
        case (r_size)
            c_SIZE_B: w_ext = {{24{~r_unsigned & w_rbyte[7]}}, w_rbyte};
            c_SIZE_H: w_ext = {{16{~r_unsigned & w_rhalf[15]}}, w_rhalf};
            default:  w_ext = w_rdata;
        endcase
    end

    // ------------------------------------------------------------ the array
    always_ff @(posedge m_clk or negedge m_rst) begin
        if (!m_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_access && r_we && !w_err) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    r_mem[w_mem_idx][8*k +: 8] <= w_wlanes[8*k +: 8];
                end
            end
        end
    end

    // Load data is sticky across stores; only loads and errors replace it.
    always_ff @(posedge m_clk or negedge m_rst) begin
        if (!m_rst) begin
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_load_data <= '0;
        end else begin
            r_ack <= w_access;
            if (w_access) begin
                r_err <= w_err;
                if (w_err) begin
                    r_load_data <= '0;
                end else if (!r_we) begin
                    r_load_data <= w_ext;
                end
            end
        end
    end

    assign m_o_ack       = r_ack;
    assign m_o_err       = r_err;
    assign m_o_load_data = r_load_data;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_ctrl
// Brief    : Three DUTs (WAIT_CYCLES 0/1/3) on shared inputs, checked against
//            a byte-array reference model.
// Revision : 1.0
// ============================================================================
module tb_data_memory_ctrl;

    localparam int c_DEPTH = 256;
    localparam int c_N     = 3;

    logic        m_clk = 1'b0;
    logic        m_rst = 1'b0;
    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic [1:0]  size  = 2'b00;
    logic        uns   = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] sdata = '0;

    logic [c_N-1:0] busy;
    logic [c_N-1:0] ack;
    logic [c_N-1:0] err;
    logic [31:0]    ld [c_N];

    int errors = 0;
    int checks = 0;

    logic [7:0]  mdl_mem [c_DEPTH*4];
    logic [31:0] mdl_ld;
    logic        mdl_err;

    always #5 m_clk = ~m_clk;

    genvar g;
    generate
        for (g = 0; g < c_N; g++) begin : g_dut
            data_memory_ctrl #(
                .DWIDTH      (32),
                .AWIDTH_MEM  (32),
                .DEPTH       (c_DEPTH),
                .WAIT_CYCLES ((g == 0) ? 0 : ((g == 1) ? 1 : 3))
            ) u_dut (
                .m_clk          (m_clk),
                .m_rst          (m_rst),
                .m_i_req        (req),
                .m_i_we         (we),
                .m_i_size       (size),
                .m_i_unsigned   (uns),
                .m_i_addr       (addr),
                .m_i_store_data (sdata),
                .m_o_busy       (busy[g]),
                .m_o_ack        (ack[g]),
                .m_o_load_data  (ld[g]),
                .m_o_err        (err[g])
            );
        end
    endgenerate

    function automatic int wait_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
    endfunction

    // ------------------------------------------------------ reference model
    function automatic bit mdl_is_err(input logic [1:0] s, input logic [31:0] a);
        if (s == 2'b11) return 1'b1;
        if (s == 2'b01 && a[0]) return 1'b1;
        if (s == 2'b10 && a[1:0] != 2'b00) return 1'b1;
        return (a >> 2) >= 32'(c_DEPTH);
    endfunction

    function automatic logic [31:0] mdl_read(input logic [1:0] s, input logic u, input logic [31:0] a);
        logic [31:0] v = '0;
        int n = 1 << s;
        for (int k = 0; k < n; k++) v = v | (32'(mdl_mem[int'(a) + k]) << (8 * k));
        if (s == 2'b00 && !u) v = {{24{v[7]}}, v[7:0]};
        if (s == 2'b01 && !u) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic mdl_apply(input logic w, input logic [1:0] s, input logic u,
                             input logic [31:0] a, input logic [31:0] d);
        if (mdl_is_err(s, a)) begin
            mdl_ld  = '0;
            mdl_err = 1'b1;
        end else begin
            mdl_err = 1'b0;
            if (w) begin
                for (int k = 0; k < (1 << s); k++) mdl_mem[int'(a) + k] = d[8*k +: 8];
            end else begin
                mdl_ld = mdl_read(s, u, a);
            end
        end
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < c_DEPTH*4; i++) mdl_mem[i] = 8'h00;
        mdl_ld  = '0;
        mdl_err = 1'b0;
    endtask

    // One transaction seen by all three instances; each one's timing and result is checked.
    task automatic do_txn(input string name, input logic t_we, input logic [1:0] t_size,
                          input logic t_uns, input logic [31:0] t_addr, input logic [31:0] t_data,
                          input bit t_chk, input logic [31:0] t_exp);
        int          lat    [c_N];
        int          nack   [c_N];
        int          nbusy  [c_N];
        logic [31:0] got_ld [c_N];
        logic        got_err[c_N];
        @(negedge m_clk);
        we = t_we; size = t_size; uns = t_uns; addr = t_addr; sdata = t_data; req = 1'b1;
        @(posedge m_clk);
        #1;
        req = 1'b0;
        mdl_apply(t_we, t_size, t_uns, t_addr, t_data);
        for (int i = 0; i < c_N; i++) begin
            lat[i] = -1; nack[i] = 0; nbusy[i] = 0; got_ld[i] = 'x; got_err[i] = 1'bx;
        end
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (cyc > 0) begin
                @(posedge m_clk);
                #1;
            end
            for (int i = 0; i < c_N; i++) begin
                if (busy[i]) nbusy[i]++;
                if (ack[i]) begin
                    nack[i]++; lat[i] = cyc; got_ld[i] = ld[i]; got_err[i] = err[i];
                end
            end
        end
        for (int i = 0; i < c_N; i++) begin
            checks++;
            if (nack[i] !== 1 || lat[i] !== wait_of(i) + 1) begin
                errors++;
                $display("FAIL %s inst%0d ack: count %0d latency %0d, required count 1 latency %0d",
                         name, i, nack[i], lat[i], wait_of(i) + 1);
            end
            checks++;
            if (nbusy[i] !== wait_of(i) + 1) begin
                errors++;
                $display("FAIL %s inst%0d busy cycles: got %0d, required %0d", name, i, nbusy[i], wait_of(i) + 1);
            end
            checks++;
            if (got_err[i] !== mdl_err) begin
                errors++;
                $display("FAIL %s inst%0d err: got %b, required %b", name, i, got_err[i], mdl_err);
            end
            checks++;
            if (got_ld[i] !== mdl_ld || ld[i] !== mdl_ld) begin
                errors++;
                $display("FAIL %s inst%0d load_data: at ack %h, held %h, required %h",
                         name, i, got_ld[i], ld[i], mdl_ld);
            end
            if (t_chk) begin
                checks++;
                if (got_ld[i] !== t_exp) begin
                    errors++;
                    $display("FAIL %s inst%0d expected value: got %h, required %h", name, i, got_ld[i], t_exp);
                end
            end
        end
    endtask

    task automatic pulse_reset(input string name);
        @(negedge m_clk);
        m_rst = 1'b0;
        #1;
        for (int i = 0; i < c_N; i++) begin
            checks++;
            if (busy[i] !== 1'b0 || ack[i] !== 1'b0 || err[i] !== 1'b0 || ld[i] !== 32'h0) begin
                errors++;
                $display("FAIL %s inst%0d outputs in reset: busy %b ack %b err %b ld %h, required 0 0 0 0",
                         name, i, busy[i], ack[i], err[i], ld[i]);
            end
        end
        @(negedge m_clk);
        m_rst = 1'b1;
        mdl_clear();
    endtask

    // --------------------------------------------------------------- tests
    task automatic test_reset();
        mdl_clear();
        repeat (2) @(posedge m_clk);
        pulse_reset("reset_initial");
        for (int w = 0; w < 4; w++) begin
            do_txn("reset_fill", 1'b1, 2'b10, 1'b0, 32'(w * 4), $urandom | 32'h1, 1'b0, '0);
        end
        do_txn("reset_fill_ld", 1'b0, 2'b10, 1'b0, 32'h4, '0, 1'b0, '0);
        pulse_reset("reset_pulse");
        do_txn("reset_lw0", 1'b0, 2'b10, 1'b0, 32'h0, '0, 1'b1, 32'h0);
        do_txn("reset_lwC", 1'b0, 2'b10, 1'b0, 32'hC, '0, 1'b1, 32'h0);
    endtask

    task automatic test_latency();
        do_txn("lat_sw", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, '0);
        do_txn("lat_lw", 1'b0, 2'b10, 1'b0, 32'h10, '0, 1'b1, 32'hDEADBEEF);
    endtask

    task automatic test_lanes();
        do_txn("lane_sw0",  1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, '0);
        do_txn("lane_sb",   1'b1, 2'b00, 1'b0, 32'h23, 32'hFFFFFF80, 1'b0, '0);
        do_txn("lane_lw",   1'b0, 2'b10, 1'b0, 32'h20, '0, 1'b1, 32'h80000000);
        do_txn("lane_lb",   1'b0, 2'b00, 1'b0, 32'h23, '0, 1'b1, 32'hFFFFFF80);
        do_txn("lane_lbu",  1'b0, 2'b00, 1'b1, 32'h23, '0, 1'b1, 32'h00000080);
        do_txn("lane_sh",   1'b1, 2'b01, 1'b0, 32'h22, 32'h12348001, 1'b0, '0);
        do_txn("lane_lh",   1'b0, 2'b01, 1'b0, 32'h22, '0, 1'b1, 32'hFFFF8001);
        do_txn("lane_lhu",  1'b0, 2'b01, 1'b1, 32'h22, '0, 1'b1, 32'h00008001);
        do_txn("lane_lw2",  1'b0, 2'b10, 1'b1, 32'h20, '0, 1'b1, 32'h80010000);
    endtask

    task automatic test_errors();
        do_txn("err_sh_odd",  1'b1, 2'b01, 1'b0, 32'h21, 32'hAAAA, 1'b1, 32'h0);
        do_txn("err_after",   1'b0, 2'b10, 1'b0, 32'h20, '0, 1'b1, 32'h80010000);
        do_txn("err_lw_mis",  1'b0, 2'b10, 1'b0, 32'h22, '0, 1'b1, 32'h0);
        do_txn("err_size3",   1'b0, 2'b11, 1'b0, 32'h20, '0, 1'b1, 32'h0);
        do_txn("err_oob",     1'b0, 2'b10, 1'b0, 32'(c_DEPTH * 4), '0, 1'b1, 32'h0);
        do_txn("err_clear",   1'b0, 2'b10, 1'b0, 32'(c_DEPTH * 4 - 4), '0, 1'b0, '0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int          r = int'($urandom_range(0, 9));
            logic [1:0]  s = (r < 3) ? 2'b00 : ((r < 6) ? 2'b01 : ((r < 9) ? 2'b10 : 2'b11));
            logic [31:0] a = 32'($urandom_range(0, c_DEPTH * 4 + 15));
            if (s != 2'b11 && $urandom_range(0, 4) != 0) a = a & ~((32'd1 << s) - 32'd1);
            do_txn("random", 1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, $urandom, 1'b0, '0);
        end
    endtask

    // req held high: each instance accepts every WAIT+2 edges and ignores the rest.
    task automatic test_back_to_back();
        logic [31:0] hist [32];
        int          cnt;
        for (int e = 0; e < 32; e++) begin
            @(negedge m_clk);
            hist[e] = 32'($urandom_range(0, c_DEPTH + 3) * 4);
            if ($urandom_range(0, 7) == 0) hist[e] = hist[e] + 32'd2;
            we = 1'b0; size = 2'b10; uns = 1'b0; addr = hist[e]; req = 1'b1;
            @(posedge m_clk);
            #1;
            for (int i = 0; i < c_N; i++) begin
                int   p       = wait_of(i) + 2;
                logic exp_ack = ((e % p) == wait_of(i) + 1);
                checks++;
                if (ack[i] !== exp_ack || busy[i] !== !exp_ack) begin
                    errors++;
                    $display("FAIL b2b inst%0d edge %0d: ack %b busy %b, required ack %b busy %b",
                             i, e, ack[i], busy[i], exp_ack, !exp_ack);
                end
                if (exp_ack) begin
                    logic [31:0] a  = hist[e - wait_of(i) - 1];
                    logic        xe = mdl_is_err(2'b10, a);
                    logic [31:0] xd = xe ? 32'h0 : mdl_read(2'b10, 1'b0, a);
                    checks++;
                    if (err[i] !== xe || ld[i] !== xd) begin
                        errors++;
                        $display("FAIL b2b inst%0d data @%h: err %b ld %h, required err %b ld %h",
                                 i, a, err[i], ld[i], xe, xd);
                    end
                end
            end
        end
        @(negedge m_clk);
        req = 1'b0;
        cnt = 0;
        while (busy != '0 && cnt < 8) begin
            @(negedge m_clk);
            cnt++;
        end
        checks++;
        if (busy != '0) begin
            errors++;
            $display("FAIL b2b drain: busy %b, required 000", busy);
        end
    endtask

    task automatic test_reset_midop();
        @(negedge m_clk);
        we = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h30; sdata = 32'h12345678; req = 1'b1;
        @(posedge m_clk);
        #1;
        req = 1'b0;
        repeat (2) @(posedge m_clk);
        #1;
        checks++;
        if (busy[2] !== 1'b1) begin
            errors++;
            $display("FAIL midop inst2 busy before reset: got %b, required 1", busy[2]);
        end
        pulse_reset("midop_reset");
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(posedge m_clk);
            #1;
            checks++;
            if (ack !== '0 || busy !== '0) begin
                errors++;
                $display("FAIL midop after reset cyc %0d: ack %b busy %b, required 000 000", cyc, ack, busy);
            end
        end
        do_txn("midop_lw", 1'b0, 2'b10, 1'b0, 32'h30, '0, 1'b1, 32'h0);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_lanes();
        test_errors();
        test_random();
        test_back_to_back();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
